// File: rtl/seg7_pkg.sv
// Seven-segment glyph table and inactive-level constants shared by the scanner.
// Segment vectors are ordered g..a and are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic       DP_OFF  = 1'b1;

    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] g;
        g = SEG_OFF;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_slot_timer.sv
// Slot/digit scan counters: slot_cnt 0..DIV-1, idx advances on each slot wrap.
// frame_tick and phase are combinational from the counters; no backpressure.
module seg7_slot_timer #(
    parameter int  DIV      = 16,
    parameter int  NDIGITS  = 8,
    parameter int  BRIGHT_W = 4,
    localparam int CNT_W    = (DIV > 1) ? $clog2(DIV) : 1,
    localparam int IDX_W    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic [CNT_W-1:0]    slot_cnt,
    output logic [IDX_W-1:0]    idx,
    output logic [BRIGHT_W-1:0] phase,
    output logic                frame_tick
);

    localparam int STEP = DIV >> BRIGHT_W;

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_wrap, idx_wrap;

    always_comb begin
        slot_wrap  = (slot_cnt_q == CNT_W'(DIV - 1));
        idx_wrap   = (idx_q == IDX_W'(NDIGITS - 1));
        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign slot_cnt   = slot_cnt_q;
    assign idx        = idx_q;
    assign frame_tick = slot_wrap & idx_wrap;
    // Brightness phase: which of the 2**BRIGHT_W equal sub-slots we are in.
    assign phase      = BRIGHT_W'(slot_cnt_q / CNT_W'(STEP));

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed hex 7-seg scanner with frame-synchronous shadow update, PWM and guard.
// seg/dp/an registered (1 cycle); load always accepted. Optional LZ_SUPPRESS_EN blanks leading zeros.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIGITS   = 8,
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 380,
    parameter int BRIGHT_W  = 4,
    parameter int GUARD_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   data_in,
    input  logic [NDIGITS-1:0]     blank_in,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic                   load,
    input  logic [BRIGHT_W-1:0]    bright,
    output logic                   pending,
    output logic                   frame_tick,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NDIGITS-1:0]     an
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef logic [NDIGITS-1:0][3:0] nib_arr_t;

    logic [CNT_W-1:0]    slot_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] phase;

    seg7_slot_timer #(
        .DIV      (DIV),
        .NDIGITS  (NDIGITS),
        .BRIGHT_W (BRIGHT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .slot_cnt   (slot_cnt),
        .idx        (idx),
        .phase      (phase),
        .frame_tick (frame_tick)
    );

    nib_arr_t           pend_data_q, pend_data_d, act_data_q, act_data_d, src_data;
    logic [NDIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d, src_blank;
    logic [NDIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d, src_dp;
    logic [NDIGITS-1:0] lz_mask;
    logic               pending_q, pending_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [NDIGITS-1:0] an_q, an_d;
`ifdef LZ_SUPPRESS_EN
    logic               lead;
`endif

    // A load coinciding with the frame boundary bypasses the shadow regs.
    always_comb begin
        src_data  = load ? nib_arr_t'(data_in) : pend_data_q;
        src_blank = load ? blank_in : pend_blank_q;
        src_dp    = load ? dp_in : pend_dp_q;

        lz_mask = '0;
`ifdef LZ_SUPPRESS_EN
        lead = 1'b1;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            if (lead && (src_data[i] == 4'h0) && !src_dp[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
`endif

        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pending_d    = pending_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;

        if (frame_tick) begin
            if (load || pending_q) begin
                act_data_d  = src_data;
                act_blank_d = src_blank | lz_mask;
                act_dp_d    = src_dp;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_data_d  = nib_arr_t'(data_in);
            pend_blank_d = blank_in;
            pend_dp_d    = dp_in;
            pending_d    = 1'b1;
        end
    end

    // Guard cycles at slot start keep the previous digit's anode off while seg settles.
    always_comb begin
        an_d = '1;
        if ((slot_cnt >= CNT_W'(GUARD_CYC)) && !act_blank_q[idx] &&
            ((phase < bright) || (&bright))) begin
            an_d[idx] = 1'b0;
        end
        seg_d = seg7_hex(act_data_q[idx]);
        dp_d  = ~act_dp_q[idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data_q  <= '0;
            pend_blank_q <= '1;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            act_data_q   <= '0;
            act_blank_q  <= '1;
            act_dp_q     <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= '1;
        end else begin
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign pending = pending_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-counting reference model queues expected
// outputs per clock; a monitor pops and compares every cycle.
module tb_seg7_scan_ctrl;

    localparam int N       = 4;
    localparam int CLK_HZ  = 1600;
    localparam int SCAN_HZ = 100;
    localparam int BW      = 2;
    localparam int GUARD   = 1;
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int FRAME   = DIV * N;
    localparam int STEP    = DIV / (1 << BW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   data_in = '0;
    logic [3:0]    blank_in = '0;
    logic [3:0]    dp_in = '0;
    logic          load = 1'b0;
    logic [1:0]    bright = '0;
    logic          pending, frame_tick, dp;
    logic [6:0]    seg;
    logic [3:0]    an;

    seg7_scan_ctrl #(
        .NDIGITS   (N),
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BRIGHT_W  (BW),
        .GUARD_CYC (GUARD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .load       (load),
        .bright     (bright),
        .pending    (pending),
        .frame_tick (frame_tick),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       pending;
        logic       ft;
    } obs_t;

    obs_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    // Reference model: time since reset plus the two register banks as plain values.
    int          t = 0;
    logic [15:0] m_data = '0, p_data = '0;
    logic [3:0]  m_blank = '1, p_blank = '1;
    logic [3:0]  m_dp = '0, p_dp = '0;
    logic        m_pend = 1'b0;
    logic [1:0]  cur_bright = 2'd3;

    // Lit segments (active-high, bit0=a .. bit6=g) for each hex glyph.
    function automatic logic [6:0] lit_segments(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic bit at_boundary(input int tt);
        return (tt % FRAME) == FRAME - 1;
    endfunction

    task automatic commit(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        logic [3:0] sup;
        sup = '0;
`ifdef LZ_SUPPRESS_EN
        for (int i = N - 1; i >= 1; i--) begin
            if (d[4*i +: 4] == 4'h0 && !p[i]) sup[i] = 1'b1;
            else break;
        end
`endif
        m_data  = d;
        m_blank = b | sup;
        m_dp    = p;
    endtask

    task automatic step(input logic rst_i, input logic ld, input logic [15:0] d,
                        input logic [3:0] b, input logic [3:0] p, input logic [1:0] br);
        obs_t e;
        int   slot, dig;
        @(negedge clk);
        reset = rst_i; load = ld; data_in = d; blank_in = b; dp_in = p; bright = br;
        if (rst_i) begin
            t = 0; m_data = '0; m_blank = '1; m_dp = '0;
            p_data = '0; p_blank = '1; p_dp = '0; m_pend = 1'b0;
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, pending: 1'b0, ft: 1'b0};
        end else begin
            slot = t % DIV;
            dig  = (t / DIV) % N;
            e.an = 4'hF;
            if (slot >= GUARD && !m_blank[dig] && ((slot / STEP) < int'(br) || br == 2'd3))
                e.an[dig] = 1'b0;
            e.seg = ~lit_segments(m_data[4*dig +: 4]);
            e.dp  = ~m_dp[dig];
            if (at_boundary(t)) begin
                if (ld) commit(d, b, p);
                else if (m_pend) commit(p_data, p_blank, p_dp);
                m_pend = 1'b0;
            end else if (ld) begin
                p_data = d; p_blank = b; p_dp = p; m_pend = 1'b1;
            end
            t++;
            e.pending = m_pend;
            e.ft      = at_boundary(t);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, cur_bright);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        step(1'b0, 1'b1, d, b, p, cur_bright);
    endtask

    task automatic idle_to_boundary();
        for (int k = 0; k < FRAME && !at_boundary(t); k++) idle(1);
    endtask

    // Monitor: the DUT presents a fresh output set every cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{an: an, seg: seg, dp: dp, pending: pending, ft: frame_tick};
                n_total++;
                if (a === e) n_pass++;
                else $display("FAIL outputs cyc=%0d got an=%h seg=%h dp=%b pend=%b ft=%b want an=%h seg=%h dp=%b pend=%b ft=%b",
                              cyc, a.an, a.seg, a.dp, a.pending, a.ft, e.an, e.seg, e.dp, e.pending, e.ft);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rl;
        logic [15:0] rd;
        logic [3:0]  rb, rp;

        // Reset held three cycles, then dark until a load lands.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 2'd3);
        cur_bright = 2'd3;
        idle(5);

        // Load at cycle 5, applied at first frame boundary.
        do_load(16'h12AF, 4'h0, 4'h0);
        idle(190);

        // PWM levels.
        cur_bright = 2'd1; idle(64);
        cur_bright = 2'd2; idle(64);
        cur_bright = 2'd0; idle(64);
        cur_bright = 2'd3;

        // Two loads within one frame: last wins; then a load exactly on the boundary.
        idle_to_boundary(); idle(10);
        do_load(16'h1111, 4'h0, 4'h0); idle(20);
        do_load(16'h2222, 4'h0, 4'h0); idle(100);
        idle_to_boundary();
        do_load(16'h5A5A, 4'h0, 4'h0); idle(70);

        // Per-digit blank and decimal point.
        do_load(16'h9876, 4'b0100, 4'b0001); idle(140);

        // Leading zeros.
        do_load(16'h0030, 4'h0, 4'h0); idle(140);
        do_load(16'h0000, 4'h0, 4'h0); idle(140);
        do_load(16'h0000, 4'h0, 4'b0100); idle(140);

        // Randomized traffic, including boundary loads and bright changes.
        for (int k = 0; k < 2000; k++) begin
            rl = ($urandom_range(0, 19) == 0) || (at_boundary(t) && $urandom_range(0, 2) == 0);
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rd[15:8] = 8'h00;
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 49) == 0) cur_bright = 2'($urandom);
            step(1'b0, rl, rd, rb, rp, cur_bright);
        end

        // Mid-frame reset drops an outstanding pending load.
        cur_bright = 2'd3;
        idle_to_boundary(); idle(20);
        do_load(16'h4321, 4'h0, 4'h0); idle(3);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, cur_bright);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, cur_bright);
        idle(140);
        do_load(16'hBEEF, 4'h0, 4'h2); idle(140);

        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain leftover=%0d want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
